// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: sequences IF/ID/EX/MEM/WB with a bounded
// memory handshake, halt state and retired-instruction counter.
module multicycle_control_fsm #(
    parameter int OPCODE_W    = 7,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                bcond,
    input  logic                halt_cond,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                pc_write,
    output logic [1:0]          pc_source,
    output logic                is_ecall,
    output logic                halted,
    output logic                mem_timeout,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    instr_retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_JALR   = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = OPCODE_W'(7'b1110011);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               req;
    logic               known_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        known_op = (opcode == OP_R)      || (opcode == OP_I)     ||
                   (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                   (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                   (opcode == OP_JALR);
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        timeout_d = timeout_q;
        retire    = 1'b0;
        req       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        pc_write  = 1'b0;
        pc_source = 2'd0;
        is_ecall  = 1'b0;
        halted    = 1'b0;

        // While reset is held every control output stays low.
        if (!reset) begin
            unique case (state_q)
                S_IF: begin
                    req      = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    alu_src_b = 2'd1;
                    if (opcode == OP_SYSTEM) begin
                        is_ecall = 1'b1;
                        retire   = 1'b1;
                        if (halt_cond) begin
                            state_d = S_HALT;
                        end else begin
                            pc_write  = 1'b1;
                            pc_source = 2'd2;
                            state_d   = S_IF;
                        end
                    end else if (known_op) begin
                        state_d = S_EX;
                    end else begin
                        pc_write  = 1'b1;
                        pc_source = 2'd2;
                        retire    = 1'b1;
                        state_d   = S_IF;
                    end
                end
                S_EX: begin
                    if (opcode == OP_R) begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'd2;
                        state_d   = S_WB;
                    end else if (opcode == OP_I) begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd1;
                        alu_op    = 2'd2;
                        state_d   = S_WB;
                    end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd1;
                        state_d   = S_MEM;
                    end else if (opcode == OP_BRANCH) begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'd1;
                        pc_write  = 1'b1;
                        pc_source = bcond ? 2'd1 : 2'd2;
                        retire    = 1'b1;
                        state_d   = S_IF;
                    end else if (opcode == OP_JAL) begin
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                        pc_write  = 1'b1;
                        pc_source = 2'd1;
                        retire    = 1'b1;
                        state_d   = S_IF;
                    end else if (opcode == OP_JALR) begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd1;
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                        state_d   = S_IF;
                    end else begin
                        pc_write  = 1'b1;
                        pc_source = 2'd2;
                        retire    = 1'b1;
                        state_d   = S_IF;
                    end
                end
                S_MEM: begin
                    req       = 1'b1;
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == OP_LOAD);
                    mem_write = (opcode != OP_LOAD);
                    if (mem_ready) begin
                        if (opcode == OP_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            pc_write  = 1'b1;
                            pc_source = 2'd2;
                            retire    = 1'b1;
                            state_d   = S_IF;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                    retire    = 1'b1;
                    state_d   = S_IF;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = S_IF;
                end
            endcase

            // A ready response in the limit cycle still completes normally.
            if (req && !mem_ready) begin
                if (MEM_TIMEOUT > 0 && wait_q == WAIT_LIM) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    wait_d = wait_q;
                end
            end
        end
    end

    always_comb begin
        retired_d = retired_q + CNT_W'(retire);
    end

    assign mem_timeout   = timeout_q & ~reset;
    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench: the driver queues per-cycle expectations and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // {mr,mw,iod,irw,rw,wb[2],asa,asb[2],aop[2],pw,ps[2],ec,h,to}
    localparam logic [17:0] MR     = 18'(1) << 17;
    localparam logic [17:0] MW     = 18'(1) << 16;
    localparam logic [17:0] IOD    = 18'(1) << 15;
    localparam logic [17:0] IRW    = 18'(1) << 14;
    localparam logic [17:0] RW     = 18'(1) << 13;
    localparam logic [17:0] WB_MDR = 18'(1) << 11;
    localparam logic [17:0] WB_PC4 = 18'(2) << 11;
    localparam logic [17:0] ASA    = 18'(1) << 10;
    localparam logic [17:0] ASB_IM = 18'(1) << 8;
    localparam logic [17:0] AOP_BR = 18'(1) << 6;
    localparam logic [17:0] AOP_FN = 18'(2) << 6;
    localparam logic [17:0] PW     = 18'(1) << 5;
    localparam logic [17:0] PS_OUT = 18'(1) << 3;
    localparam logic [17:0] PS_PC4 = 18'(2) << 3;
    localparam logic [17:0] EC     = 18'(1) << 2;
    localparam logic [17:0] HLT    = 18'(1) << 1;
    localparam logic [17:0] TO     = 18'(1);
    localparam logic [17:0] NONE   = 18'(0);

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [17:0] ctl;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        bcond, halt_cond, mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, reg_write;
    logic [1:0]  wb_sel, alu_src_b, alu_op, pc_source;
    logic        alu_src_a, pc_write, is_ecall, halted, mem_timeout;
    logic [2:0]  state;
    logic [31:0] instr_retired;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .OPCODE_W(7), .MEM_TIMEOUT(4), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .halt_cond(halt_cond), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_write(pc_write), .pc_source(pc_source), .is_ecall(is_ecall),
        .halted(halted), .mem_timeout(mem_timeout), .state(state),
        .instr_retired(instr_retired)
    );

    wire [17:0] ctl_act = {mem_read, mem_write, i_or_d, ir_write,
                           reg_write, wb_sel, alu_src_a, alu_src_b,
                           alu_op, pc_write, pc_source, is_ecall,
                           halted, mem_timeout};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp += 3;
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL %s state: got %0d want %0d",
                         e.name, state, e.st);
            end
            if (ctl_act !== e.ctl) begin
                n_bad++;
                $display("FAIL %s ctl: got %b want %b",
                         e.name, ctl_act, e.ctl);
            end
            if (instr_retired !== e.ret) begin
                n_bad++;
                $display("FAIL %s retired: got %0d want %0d",
                         e.name, instr_retired, e.ret);
            end
        end
    end

    task automatic step(input string nm, input logic rst,
                        input logic [6:0] op, input logic bc,
                        input logic hc, input logic rdy,
                        input logic [2:0] st, input logic [17:0] ctl,
                        input int ret);
        exp_t e;
        reset     = rst;
        opcode    = op;
        bcond     = bc;
        halt_cond = hc;
        mem_ready = rdy;
        e.name = nm;
        e.st   = st;
        e.ctl  = ctl;
        e.ret  = 32'(ret);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = '0; bcond = 0; halt_cond = 0; mem_ready = 0;
        @(posedge clk);
        #1;
        step("rst",      1, OP_R, 0, 0, 1, 0, NONE, 0);
        // R-type, ready tied high
        step("r_if",     0, OP_R, 0, 0, 1, 0, MR | IRW, 0);
        step("r_id",     0, OP_R, 0, 0, 1, 1, ASB_IM, 0);
        step("r_ex",     0, OP_R, 0, 0, 1, 2, ASA | AOP_FN, 0);
        step("r_wb",     0, OP_R, 0, 0, 1, 4, RW | PW | PS_PC4, 0);
        // LOAD with three stalled MEM cycles; ready lands on the limit cycle
        step("ld_if",    0, OP_LD, 0, 0, 1, 0, MR | IRW, 1);
        step("ld_id",    0, OP_LD, 0, 0, 1, 1, ASB_IM, 1);
        step("ld_ex",    0, OP_LD, 0, 0, 1, 2, ASA | ASB_IM, 1);
        step("ld_mem0",  0, OP_LD, 0, 0, 0, 3, MR | IOD, 1);
        step("ld_mem1",  0, OP_LD, 0, 0, 0, 3, MR | IOD, 1);
        step("ld_mem2",  0, OP_LD, 0, 0, 0, 3, MR | IOD, 1);
        step("ld_mem3",  0, OP_LD, 0, 0, 1, 3, MR | IOD, 1);
        step("ld_wb",    0, OP_LD, 0, 0, 1, 4, RW | WB_MDR | PW | PS_PC4, 1);
        // STORE with one stalled fetch
        step("st_if0",   0, OP_ST, 0, 0, 0, 0, MR, 2);
        step("st_if1",   0, OP_ST, 0, 0, 1, 0, MR | IRW, 2);
        step("st_id",    0, OP_ST, 0, 0, 1, 1, ASB_IM, 2);
        step("st_ex",    0, OP_ST, 0, 0, 1, 2, ASA | ASB_IM, 2);
        step("st_mem",   0, OP_ST, 0, 0, 1, 3, MW | IOD | PW | PS_PC4, 2);
        // Branch taken / not taken
        step("bt_if",    0, OP_BR, 1, 0, 1, 0, MR | IRW, 3);
        step("bt_id",    0, OP_BR, 1, 0, 1, 1, ASB_IM, 3);
        step("bt_ex",    0, OP_BR, 1, 0, 1, 2, ASA | AOP_BR | PW | PS_OUT, 3);
        step("bn_if",    0, OP_BR, 0, 0, 1, 0, MR | IRW, 4);
        step("bn_id",    0, OP_BR, 0, 0, 1, 1, ASB_IM, 4);
        step("bn_ex",    0, OP_BR, 0, 0, 1, 2, ASA | AOP_BR | PW | PS_PC4, 4);
        // JAL and JALR
        step("jal_if",   0, OP_JAL, 0, 0, 1, 0, MR | IRW, 5);
        step("jal_id",   0, OP_JAL, 0, 0, 1, 1, ASB_IM, 5);
        step("jal_ex",   0, OP_JAL, 0, 0, 1, 2, RW | WB_PC4 | PW | PS_OUT, 5);
        step("jr_if",    0, OP_JR, 0, 0, 1, 0, MR | IRW, 6);
        step("jr_id",    0, OP_JR, 0, 0, 1, 1, ASB_IM, 6);
        step("jr_ex",    0, OP_JR, 0, 0, 1, 2,
             ASA | ASB_IM | RW | WB_PC4 | PW, 6);
        // Unknown opcode retires from ID
        step("unk_if",   0, OP_LUI, 0, 0, 1, 0, MR | IRW, 7);
        step("unk_id",   0, OP_LUI, 0, 0, 1, 1, ASB_IM | PW | PS_PC4, 7);
        // I-arith
        step("i_if",     0, OP_I, 0, 0, 1, 0, MR | IRW, 8);
        step("i_id",     0, OP_I, 0, 0, 1, 1, ASB_IM, 8);
        step("i_ex",     0, OP_I, 0, 0, 1, 2, ASA | ASB_IM | AOP_FN, 8);
        step("i_wb",     0, OP_I, 0, 0, 1, 4, RW | PW | PS_PC4, 8);
        // ECALL without and with halt
        step("ec0_if",   0, OP_SYS, 0, 0, 1, 0, MR | IRW, 9);
        step("ec0_id",   0, OP_SYS, 0, 0, 1, 1, ASB_IM | EC | PW | PS_PC4, 9);
        step("ec1_if",   0, OP_SYS, 0, 1, 1, 0, MR | IRW, 10);
        step("ec1_id",   0, OP_SYS, 0, 1, 1, 1, ASB_IM | EC, 10);
        step("halt0",    0, OP_SYS, 0, 1, 1, 5, HLT, 11);
        step("halt1",    0, OP_R, 0, 0, 0, 5, HLT, 11);
        step("rst_halt", 1, OP_R, 0, 0, 0, 5, NONE, 11);
        // Fetch timeout with limit 4
        step("to_if0",   0, OP_R, 0, 0, 0, 0, MR, 0);
        step("to_if1",   0, OP_R, 0, 0, 0, 0, MR, 0);
        step("to_if2",   0, OP_R, 0, 0, 0, 0, MR, 0);
        step("to_if3",   0, OP_R, 0, 0, 0, 0, MR, 0);
        step("to_halt",  0, OP_R, 0, 0, 1, 5, HLT | TO, 0);
        step("to_rst",   1, OP_R, 0, 0, 0, 5, NONE, 0);
        step("post_if",  0, OP_R, 0, 0, 0, 0, MR, 0);
        step("post_if1", 0, OP_R, 0, 0, 1, 0, MR | IRW, 0);
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
